// File: rtl/core_pkg.sv
// core_pkg: sequencer state encoding, memory access formats and the reset instruction
package core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_COMMIT,
        ST_FAULT
    } seq_state_t;

    localparam logic [2:0]  FMT_B    = 3'b000;
    localparam logic [2:0]  FMT_H    = 3'b001;
    localparam logic [2:0]  FMT_W    = 3'b010;
    localparam logic [2:0]  FMT_BU   = 3'b100;
    localparam logic [2:0]  FMT_HU   = 3'b101;
    localparam logic [31:0] NOP_INSN = 32'h00000013;

    // Halves need an even address, words a 4-byte aligned one; bytes never misalign
    function automatic logic misaligned(input logic [2:0] fmt, input logic [1:0] addr);
        return (fmt[1:0] == FMT_H[1:0] && addr[0]) || (fmt[1:0] == FMT_W[1:0] && addr != 2'b00);
    endfunction

endpackage

// File: rtl/core_seq_timeout.sv
// seq_timeout: counts stalled bus-request cycles and flags the one that exhausts the budget
module seq_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    // Restart the budget on every state change so each transfer is timed on its own
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            cnt <= '0;
        else if (i_clr)
            cnt <= '0;
        else if (i_en)
            cnt <= cnt + CW'(1);

    assign o_expired = (TIMEOUT != 0) && i_en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/core_seq.sv
// core_seq: multi-cycle fetch/execute/memory/commit sequencer sharing one bus port
module core_seq
    import core_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_alu_res,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_mem_fmt,
    input  logic            i_mem_w_en,
    input  logic            i_mem_r_en,
    input  logic            i_reg_w_en,
    output logic            o_bus_req,
    output logic            o_bus_we,
    output logic [XLEN-1:0] o_bus_addr,
    output logic [XLEN-1:0] o_bus_wdata,
    output logic [2:0]      o_bus_fmt,
    input  logic            i_bus_ack,
    input  logic [XLEN-1:0] i_bus_rdata,
    input  logic            i_bus_err,
    output logic [31:0]     o_ir,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_pc_en,
    output logic            o_reg_w_en,
    output logic            o_fault
);
    seq_state_t state, state_nx;
    logic       pc_bad, ldst, ldst_bad, stall, expired, fail;

    assign pc_bad   = i_pc[1:0] != 2'b00;
    assign ldst     = i_mem_r_en || i_mem_w_en;
    assign ldst_bad = (i_mem_r_en && i_mem_w_en) || misaligned(i_mem_fmt, i_alu_res[1:0]);

    // Reset gates the request directly so it drops the moment reset rises
    assign o_bus_req   = !i_rst && ((state == ST_FETCH && !pc_bad) || state == ST_MEM);
    assign o_bus_we    = state == ST_MEM && i_mem_w_en;
    assign o_bus_addr  = state == ST_MEM ? i_alu_res : i_pc;
    assign o_bus_wdata = i_rs2;
    assign o_bus_fmt   = state == ST_MEM ? i_mem_fmt : FMT_W;

    assign o_pc_en    = !i_rst && state == ST_COMMIT;
    assign o_reg_w_en = o_pc_en && i_reg_w_en;
    assign o_fault    = state == ST_FAULT;

    assign stall = o_bus_req && !i_bus_ack;
    assign fail  = o_bus_req && (i_bus_err || expired);

    seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (state_nx != state),
        .i_en     (stall),
        .o_expired(expired)
    );

    // Next state: a bus error outranks an ack arriving in the same cycle
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_FETCH:  state_nx = (pc_bad || fail) ? ST_FAULT : i_bus_ack ? ST_EXEC : ST_FETCH;
            ST_EXEC:   state_nx = !ldst ? ST_COMMIT : ldst_bad ? ST_FAULT : ST_MEM;
            ST_MEM:    state_nx = fail ? ST_FAULT : i_bus_ack ? ST_COMMIT : ST_MEM;
            ST_COMMIT: state_nx = ST_FETCH;
            default:   state_nx = ST_FAULT;
        endcase
    end

    // State register; FAULT holds until reset
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            state <= ST_FETCH;
        else
            state <= state_nx;

    // Instruction register captures only a clean fetch completion
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            o_ir <= NOP_INSN;
        else if (state == ST_FETCH && state_nx == ST_EXEC)
            o_ir <= i_bus_rdata[31:0];

    // Load data captures only a clean load completion
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            o_load_data <= '0;
        else if (state == ST_MEM && state_nx == ST_COMMIT && i_mem_r_en)
            o_load_data <= i_bus_rdata;

endmodule
